sad_search_sequencer: RTL and testbench

Controls a full SAD block-match search. It issues candidate-index pairs (lane A and lane B) into stage 1 of the SAD pipeline and tags the last pair with TriggerBoss. It folds the per-cycle A/B minima that leave the final SAD stage into a running minimum, then reports the winning index and value. It sits between the search-start logic and the SAD stage chain, and owns the sequencing of every pipeline register from SAD1 to SAD7.

---
 rtl/sad_search_sequencer.sv | 153 +++++++++++++++
 tb/tb_sad_search_sequencer.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sad_search_sequencer.sv
// Sequences one SAD block-match search: issues candidate pairs into SAD1, folds the
// final-stage A/B minima into a running best, and reports the winner with a done pulse.
module sad_search_sequencer #(
  parameter int NUM_CANDIDATES = 64,
  parameter int DRAIN_LIMIT    = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        hold,
  output logic        issue_valid,
  output logic [15:0] issue_index_a,
  output logic [15:0] issue_index_b,
  output logic        issue_trigger_boss,
  input  logic        res_valid,
  input  logic        res_trigger_boss,
  input  logic [15:0] res_index_a,
  input  logic [15:0] res_index_b,
  input  logic [13:0] res_value_a,
  input  logic [13:0] res_value_b,
  output logic        busy,
  output logic        done,
  output logic [15:0] best_index,
  output logic [13:0] best_value,
  output logic        err
);

  localparam int          P          = NUM_CANDIDATES / 2;
  localparam logic [14:0] LAST_K     = 15'(P - 1);
  localparam logic [15:0] P_CNT      = 16'(P);
  localparam logic [15:0] DRAIN_LAST = 16'(DRAIN_LIMIT - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [14:0] k_q, k_d;
  logic [15:0] drain_cnt_q, drain_cnt_d;
  logic [15:0] res_cnt_q, res_cnt_d;
  logic [15:0] best_index_q, best_index_d;
  logic [13:0] best_value_q, best_value_d;
  logic        err_q, err_d;
  logic        iss_valid_q, iss_valid_d;
  logic [15:0] iss_a_q, iss_a_d;
  logic [15:0] iss_b_q, iss_b_d;
  logic        iss_tb_q, iss_tb_d;
  logic [29:0] win;

  // Lane A wins ties because it always carries the lower candidate index.
  function automatic logic [29:0] pick_winner(input logic [15:0] ia, input logic [13:0] va,
                                              input logic [15:0] ib, input logic [13:0] vb);
    return (va <= vb) ? {ia, va} : {ib, vb};
  endfunction

  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    drain_cnt_d  = drain_cnt_q;
    res_cnt_d    = res_cnt_q;
    best_index_d = best_index_q;
    best_value_d = best_value_q;
    err_d        = err_q;
    iss_valid_d  = 1'b0;
    iss_a_d      = 16'd0;
    iss_b_d      = 16'd0;
    iss_tb_d     = 1'b0;
    win          = pick_winner(res_index_a, res_value_a, res_index_b, res_value_b);

    // Strict compare keeps the earliest index when a later pair only ties the best.
    if ((state_q == S_ISSUE || state_q == S_DRAIN) && res_valid) begin
      if (win[13:0] < best_value_q) begin
        best_index_d = win[29:14];
        best_value_d = win[13:0];
      end
      res_cnt_d = res_cnt_q + 16'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d      = S_ISSUE;
          k_d          = 15'd0;
          best_index_d = 16'hFFFF;
          best_value_d = 14'h3FFF;
          err_d        = 1'b0;
          res_cnt_d    = 16'd0;
        end
      end
      S_ISSUE: begin
        drain_cnt_d = 16'd0;
        if (!hold) begin
          iss_valid_d = 1'b1;
          iss_a_d     = {k_q, 1'b0};
          iss_b_d     = {k_q, 1'b1};
          iss_tb_d    = (k_q == LAST_K);
          k_d         = k_q + 15'd1;
          if (k_q == LAST_K) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (res_valid && res_trigger_boss) begin
          state_d = S_DONE;
          if (res_cnt_q + 16'd1 != P_CNT) err_d = 1'b1;
        end else if (drain_cnt_q == DRAIN_LAST) begin
          state_d = S_DONE;
          err_d   = 1'b1;
        end else begin
          drain_cnt_d = drain_cnt_q + 16'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      k_q          <= 15'd0;
      drain_cnt_q  <= 16'd0;
      res_cnt_q    <= 16'd0;
      best_index_q <= 16'hFFFF;
      best_value_q <= 14'h3FFF;
      err_q        <= 1'b0;
      iss_valid_q  <= 1'b0;
      iss_a_q      <= 16'd0;
      iss_b_q      <= 16'd0;
      iss_tb_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      drain_cnt_q  <= drain_cnt_d;
      res_cnt_q    <= res_cnt_d;
      best_index_q <= best_index_d;
      best_value_q <= best_value_d;
      err_q        <= err_d;
      iss_valid_q  <= iss_valid_d;
      iss_a_q      <= iss_a_d;
      iss_b_q      <= iss_b_d;
      iss_tb_q     <= iss_tb_d;
    end
  end

  assign issue_valid        = iss_valid_q;
  assign issue_index_a      = iss_a_q;
  assign issue_index_b      = iss_b_q;
  assign issue_trigger_boss = iss_tb_q;
  assign busy               = (state_q == S_ISSUE) || (state_q == S_DRAIN);
  assign done               = (state_q == S_DONE);
  assign best_index         = best_index_q;
  assign best_value         = best_value_q;
  assign err                = err_q;

endmodule

// File: tb/tb_sad_search_sequencer.sv
// Bench for sad_search_sequencer: 7-stage delay model of the SAD chain, scoreboard
// queues for issued pairs and search results, directed searches with hand-computed answers.
module tb_sad_search_sequencer;

  localparam int NC    = 8;
  localparam int P     = NC / 2;
  localparam int DL    = 15;
  localparam int DEPTH = 7;

  logic        clk = 1'b0;
  logic        rst_n, start, hold;
  logic        issue_valid, issue_trigger_boss;
  logic [15:0] issue_index_a, issue_index_b;
  logic        res_valid, res_trigger_boss;
  logic [15:0] res_index_a, res_index_b;
  logic [13:0] res_value_a, res_value_b;
  logic        busy, done, err;
  logic [15:0] best_index;
  logic [13:0] best_value;

  sad_search_sequencer #(.NUM_CANDIDATES(NC), .DRAIN_LIMIT(DL)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .hold(hold),
    .issue_valid(issue_valid), .issue_index_a(issue_index_a), .issue_index_b(issue_index_b),
    .issue_trigger_boss(issue_trigger_boss),
    .res_valid(res_valid), .res_trigger_boss(res_trigger_boss),
    .res_index_a(res_index_a), .res_index_b(res_index_b),
    .res_value_a(res_value_a), .res_value_b(res_value_b),
    .busy(busy), .done(done), .best_index(best_index), .best_value(best_value), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // SAD chain stand-in: DEPTH register stages, per-candidate values from a table.
  logic        drop_tb;
  logic [13:0] vals [8];
  logic        dv  [DEPTH];
  logic        dtb [DEPTH];
  logic [15:0] dia [DEPTH];
  logic [15:0] dib [DEPTH];

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        dv[i] <= 1'b0; dtb[i] <= 1'b0; dia[i] <= 16'd0; dib[i] <= 16'd0;
      end
    end else begin
      dv[0]  <= issue_valid & ~(drop_tb & issue_trigger_boss);
      dtb[0] <= issue_trigger_boss;
      dia[0] <= issue_index_a;
      dib[0] <= issue_index_b;
      for (int i = 1; i < DEPTH; i++) begin
        dv[i] <= dv[i-1]; dtb[i] <= dtb[i-1]; dia[i] <= dia[i-1]; dib[i] <= dib[i-1];
      end
    end
  end

  logic [15:0] last_a, last_b;
  assign res_valid        = dv[DEPTH-1];
  assign res_trigger_boss = dtb[DEPTH-1];
  assign last_a           = dia[DEPTH-1];
  assign last_b           = dib[DEPTH-1];
  assign res_index_a      = last_a;
  assign res_index_b      = last_b;
  assign res_value_a      = vals[last_a[2:0]];
  assign res_value_b      = vals[last_b[2:0]];

  typedef struct {logic [15:0] bi; logic [13:0] bv; logic e; int sc; int lat;} exp_t;
  typedef struct {logic [15:0] a; logic [15:0] b; logic t;} iss_t;
  exp_t exp_q[$];
  iss_t iss_q[$];

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents an issue or a done pulse.
  iss_t mi;
  exp_t me;
  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      if (issue_valid) begin
        if (iss_q.size() == 0) check("issue_unexpected", 32'd1, 32'd0);
        else begin
          mi = iss_q.pop_front();
          check("issue_index_a", 32'(issue_index_a), 32'(mi.a));
          check("issue_index_b", 32'(issue_index_b), 32'(mi.b));
          check("issue_trigger", 32'(issue_trigger_boss), 32'(mi.t));
        end
      end else begin
        check("issue_idle_zero", {issue_index_a, issue_index_b[14:0], issue_trigger_boss}, 32'd0);
      end
      if (done) begin
        done_cnt++;
        if (exp_q.size() == 0) check("done_unexpected", 32'd1, 32'd0);
        else begin
          me = exp_q.pop_front();
          check("best_index", 32'(best_index), 32'(me.bi));
          check("best_value", 32'(best_value), 32'(me.bv));
          check("err", 32'(err), 32'(me.e));
          check("done_latency", 32'(cyc - me.sc), 32'(me.lat));
          check("busy_at_done", 32'(busy), 32'd0);
        end
      end
    end
  end

  task automatic set_vals(input logic [13:0] v0, v1, v2, v3, v4, v5, v6, v7);
    vals[0] = v0; vals[1] = v1; vals[2] = v2; vals[3] = v3;
    vals[4] = v4; vals[5] = v5; vals[6] = v6; vals[7] = v7;
  endtask

  task automatic push_search(input logic [15:0] bi, input logic [13:0] bv, input logic e,
                             input int lat);
    exp_t x;
    iss_t s;
    x.bi = bi; x.bv = bv; x.e = e; x.sc = cyc; x.lat = lat;
    exp_q.push_back(x);
    for (int k = 0; k < P; k++) begin
      s.a = 16'(2 * k); s.b = 16'(2 * k + 1); s.t = (k == P - 1);
      iss_q.push_back(s);
    end
  endtask

  task automatic wait_done();
    int n0;
    int t;
    n0 = done_cnt;
    t = 0;
    while (done_cnt == n0 && t < 80) begin
      @(negedge clk);
      t++;
    end
    if (done_cnt == n0) check("done_timeout", 32'd0, 32'd1);
    @(negedge clk);
  endtask

  task automatic run(input logic [15:0] bi, input logic [13:0] bv, input logic e, input int lat);
    @(negedge clk);
    start = 1'b1;
    push_search(bi, bv, e, lat);
    @(negedge clk);
    start = 1'b0;
    wait_done();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    int t;
    rst_n = 1'b0; start = 1'b0; hold = 1'b0; drop_tb = 1'b0;
    set_vals(14'd400, 14'd300, 14'd250, 14'd200, 14'd150, 14'd100, 14'd350, 14'd500);
    #22;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_issue_valid", 32'(issue_valid), 32'd0);
    check("rst_best_index", 32'(best_index), 32'hFFFF);
    check("rst_best_value", 32'(best_value), 32'h3FFF);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Distinct values, minimum 100 at index 5.
    run(16'd5, 14'd100, 1'b0, 13);

    // Cross-pair tie at indices 2 and 6.
    set_vals(14'd90, 14'd80, 14'd50, 14'd70, 14'd60, 14'd85, 14'd50, 14'd95);
    run(16'd2, 14'd50, 1'b0, 13);

    // Lane A / lane B tie at indices 4 and 5.
    set_vals(14'd90, 14'd80, 14'd70, 14'd60, 14'd30, 14'd30, 14'd40, 14'd50);
    run(16'd4, 14'd30, 1'b0, 13);

    // Three hold cycles after the first pair is issued.
    set_vals(14'd400, 14'd300, 14'd250, 14'd200, 14'd150, 14'd100, 14'd350, 14'd500);
    @(negedge clk);
    start = 1'b1;
    push_search(16'd5, 14'd100, 1'b0, 16);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    hold = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("hold_no_issue", 32'(issue_valid), 32'd0);
    end
    hold = 1'b0;
    wait_done();

    // Trigger-boss result lost: DRAIN times out.
    drop_tb = 1'b1;
    run(16'd5, 14'd100, 1'b1, 20);
    drop_tb = 1'b0;
    repeat (2) @(negedge clk);

    // Asynchronous reset in the middle of DRAIN.
    @(negedge clk);
    start = 1'b1;
    push_search(16'd5, 14'd100, 1'b0, 13);
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    check("pre_rst_busy", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_err", 32'(err), 32'd0);
    check("midrst_issue_valid", 32'(issue_valid), 32'd0);
    check("midrst_best_index", 32'(best_index), 32'hFFFF);
    check("midrst_best_value", 32'(best_value), 32'h3FFF);
    exp_q.delete();
    iss_q.delete();
    n0 = done_cnt;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("rst_no_done", 32'(done_cnt), 32'(n0));
    set_vals(14'd90, 14'd80, 14'd70, 14'd60, 14'd30, 14'd30, 14'd40, 14'd50);
    run(16'd4, 14'd30, 1'b0, 13);

    // start held high through the whole search and the done cycle.
    set_vals(14'd400, 14'd300, 14'd250, 14'd200, 14'd150, 14'd100, 14'd350, 14'd500);
    @(negedge clk);
    start = 1'b1;
    push_search(16'd5, 14'd100, 1'b0, 13);
    t = 0;
    while (!done && t < 40) begin
      @(negedge clk);
      t++;
    end
    check("held_start_done_seen", 32'(done), 32'd1);
    @(negedge clk);
    check("held_idle_busy", 32'(busy), 32'd0);
    check("held_idle_best_index", 32'(best_index), 32'd5);
    check("held_idle_best_value", 32'(best_value), 32'd100);
    push_search(16'd5, 14'd100, 1'b0, 13);
    @(negedge clk);
    start = 1'b0;
    check("held_accept_busy", 32'(busy), 32'd1);
    check("held_accept_best_index", 32'(best_index), 32'hFFFF);
    check("held_accept_best_value", 32'(best_value), 32'h3FFF);
    wait_done();

    repeat (3) @(negedge clk);
    check("exp_queue_empty", 32'(exp_q.size()), 32'd0);
    check("iss_queue_empty", 32'(iss_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
